// File: rtl/prf_read_stage.sv
// prf_read_stage: register-read stage for one issue lane.
//   Drives the PRF read ports straight from the issued source tags. Each
//   operand takes writeback data when a snooped port matches its tag in the
//   same cycle, otherwise the PRF read data. The highest matching port wins.
//   Operands and payload are held in a valid/ready register feeding execute.
// Optional feature: define PRF_READ_SKID_EN to add a 1-entry skid buffer
//   behind the output register. in_ready_o then comes from a register.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   flush_i                  squash all in-flight entries
//   in_valid_i/in_ready_o    issue handshake
//   in_src1_i/in_src2_i      physical source tags
//   in_payload_i             opaque payload
//   prf_addr1_o/prf_addr2_o  PRF read addresses (combinational)
//   prf_data1_i/prf_data2_i  PRF read data (same cycle)
//   wb_valid_i/addr_i/data_i writeback snoop ports (port k at slice k)
//   out_valid_o/out_ready_i  execute handshake
//   out_src1_data_o/out_src2_data_o/out_payload_o  output entry
module prf_read_stage #(
  parameter int unsigned DEPTH     = 96,
  parameter int unsigned INDEX     = 7,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned NUM_WB    = 4,
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [INDEX-1:0]        in_src1_i,
  input  logic [INDEX-1:0]        in_src2_i,
  input  logic [PAYLOAD_W-1:0]    in_payload_i,
  output logic [INDEX-1:0]        prf_addr1_o,
  output logic [INDEX-1:0]        prf_addr2_o,
  input  logic [WIDTH-1:0]        prf_data1_i,
  input  logic [WIDTH-1:0]        prf_data2_i,
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  logic [NUM_WB*INDEX-1:0] wb_addr_i,
  input  logic [NUM_WB*WIDTH-1:0] wb_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_src1_data_o,
  output logic [WIDTH-1:0]        out_src2_data_o,
  output logic [PAYLOAD_W-1:0]    out_payload_o
);

  // Tag width must address every physical register.
  if ((64'd1 << INDEX) < 64'(DEPTH)) begin : g_bad_index
    $error("prf_read_stage: INDEX too small for DEPTH");
  end

  logic [WIDTH-1:0]     w_op1;
  logic [WIDTH-1:0]     w_op2;
  logic                 w_accept;
  logic                 w_drain;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_d1;
  logic [WIDTH-1:0]     r_out_d2;
  logic [PAYLOAD_W-1:0] r_out_pl;

  assign prf_addr1_o = in_src1_i;
  assign prf_addr2_o = in_src2_i;

  // Bypass: ascending scan so the highest matching port overrides.
  always_comb begin
    w_op1 = prf_data1_i;
    w_op2 = prf_data2_i;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (wb_valid_i[k] && (wb_addr_i[k*INDEX +: INDEX] == in_src1_i)) begin
        w_op1 = wb_data_i[k*WIDTH +: WIDTH];
      end
      if (wb_valid_i[k] && (wb_addr_i[k*INDEX +: INDEX] == in_src2_i)) begin
        w_op2 = wb_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept = in_valid_i && in_ready_o && !flush_i;
  assign w_drain  = r_out_valid && out_ready_i;

`ifdef PRF_READ_SKID_EN
  logic                 r_skid_valid;
  logic [WIDTH-1:0]     r_skid_d1;
  logic [WIDTH-1:0]     r_skid_d2;
  logic [PAYLOAD_W-1:0] r_skid_pl;

  assign in_ready_o = !r_skid_valid;

  // Output register plus skid; skid only fills while the output is stalled,
  // and always drains into the output first so order is preserved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_d1     <= '0;
      r_out_d2     <= '0;
      r_out_pl     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_d1    <= '0;
      r_skid_d2    <= '0;
      r_skid_pl    <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_drain) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_d1     <= r_skid_d1;
        r_out_d2     <= r_skid_d2;
        r_out_pl     <= r_skid_pl;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_d1    <= w_op1;
        r_out_d2    <= w_op2;
        r_out_pl    <= in_payload_i;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_d1    <= w_op1;
      r_skid_d2    <= w_op2;
      r_skid_pl    <= in_payload_i;
    end
  end
`else
  assign in_ready_o = !r_out_valid || out_ready_i;

  // Single output register; a same-edge accept replaces the drained entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_d1    <= '0;
      r_out_d2    <= '0;
      r_out_pl    <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_d1    <= w_op1;
      r_out_d2    <= w_op2;
      r_out_pl    <= in_payload_i;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid_o     = r_out_valid;
  assign out_src1_data_o = r_out_d1;
  assign out_src2_data_o = r_out_d2;
  assign out_payload_o   = r_out_pl;

endmodule

// File: tb/tb_prf_read_stage.sv
// Directed bench for prf_read_stage with a behavioural PRF array.
module tb_prf_read_stage;

  localparam int unsigned INDEX     = 7;
  localparam int unsigned WIDTH     = 64;
  localparam int unsigned NUM_WB    = 4;
  localparam int unsigned PAYLOAD_W = 32;

  logic                    clk;
  logic                    reset_n;
  logic                    flush_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [INDEX-1:0]        in_src1_i;
  logic [INDEX-1:0]        in_src2_i;
  logic [PAYLOAD_W-1:0]    in_payload_i;
  logic [INDEX-1:0]        prf_addr1_o;
  logic [INDEX-1:0]        prf_addr2_o;
  logic [WIDTH-1:0]        prf_data1_i;
  logic [WIDTH-1:0]        prf_data2_i;
  logic [NUM_WB-1:0]       wb_valid_i;
  logic [NUM_WB*INDEX-1:0] wb_addr_i;
  logic [NUM_WB*WIDTH-1:0] wb_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [WIDTH-1:0]        out_src1_data_o;
  logic [WIDTH-1:0]        out_src2_data_o;
  logic [PAYLOAD_W-1:0]    out_payload_o;

  logic [WIDTH-1:0] mem [128];
  int n_tests = 0;
  int n_fail  = 0;
  logic skid;

  prf_read_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_src1_i       (in_src1_i),
    .in_src2_i       (in_src2_i),
    .in_payload_i    (in_payload_i),
    .prf_addr1_o     (prf_addr1_o),
    .prf_addr2_o     (prf_addr2_o),
    .prf_data1_i     (prf_data1_i),
    .prf_data2_i     (prf_data2_i),
    .wb_valid_i      (wb_valid_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_src1_data_o (out_src1_data_o),
    .out_src2_data_o (out_src2_data_o),
    .out_payload_o   (out_payload_o)
  );

  assign prf_data1_i = mem[prf_addr1_o];
  assign prf_data2_i = mem[prf_addr2_o];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then commit this cycle's writebacks into the PRF model.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid_i[k]) mem[wb_addr_i[k*INDEX +: INDEX]] = wb_data_i[k*WIDTH +: WIDTH];
    end
  endtask

  task automatic issue(input logic [INDEX-1:0] s1, input logic [INDEX-1:0] s2,
                       input logic [PAYLOAD_W-1:0] pl);
    in_valid_i   = 1'b1;
    in_src1_i    = s1;
    in_src2_i    = s2;
    in_payload_i = pl;
  endtask

  task automatic set_wb(input int k, input logic [INDEX-1:0] t, input logic [WIDTH-1:0] d);
    wb_valid_i[k]                = 1'b1;
    wb_addr_i[k*INDEX +: INDEX]  = t;
    wb_data_i[k*WIDTH +: WIDTH]  = d;
  endtask

  initial begin
`ifdef PRF_READ_SKID_EN
    skid = 1'b1;
`else
    skid = 1'b0;
`endif
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[5] = 64'hAA;
    mem[9] = 64'hBB;
    reset_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_src1_i = '0; in_src2_i = '0; in_payload_i = '0;
    wb_valid_i = '0; wb_addr_i = '0; wb_data_i = '0;

    #12;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_d1", out_src1_data_o, 64'd0);
    check("rst_pl", 64'(out_payload_o), 64'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", 64'(in_ready_o), 64'd1);

    // Plain read
    out_ready_i = 1'b1;
    issue(7'd5, 7'd9, 32'hCAFE0001);
    #1;
    check("addr1", 64'(prf_addr1_o), 64'd5);
    check("addr2", 64'(prf_addr2_o), 64'd9);
    tick();
    check("plain_valid", 64'(out_valid_o), 64'd1);
    check("plain_d1", out_src1_data_o, 64'hAA);
    check("plain_d2", out_src2_data_o, 64'hBB);
    check("plain_pl", 64'(out_payload_o), 64'hCAFE0001);

    // Same-cycle bypass on port 2, then the PRF holds the value next cycle
    issue(7'd12, 7'd5, 32'hCAFE0002);
    set_wb(2, 7'd12, 64'h1234);
    tick();
    wb_valid_i = '0;
    check("byp_valid", 64'(out_valid_o), 64'd1);
    check("byp_d1", out_src1_data_o, 64'h1234);
    check("byp_d2", out_src2_data_o, 64'hAA);
    issue(7'd12, 7'd12, 32'hCAFE0003);
    tick();
    check("prf_after_wb_d1", out_src1_data_o, 64'h1234);
    check("prf_after_wb_d2", out_src2_data_o, 64'h1234);

    // Multi-match on src1 (highest port wins), independent src2 bypass
    set_wb(0, 7'd7, 64'h11);
    set_wb(3, 7'd7, 64'h33);
    set_wb(1, 7'd9, 64'h99);
    issue(7'd7, 7'd9, 32'hCAFE0004);
    tick();
    wb_valid_i = '0;
    check("multi_d1", out_src1_data_o, 64'h33);
    check("multi_d2", out_src2_data_o, 64'h99);

    // A valid writeback to another tag must not disturb src1
    set_wb(0, 7'd3, 64'hDEAD);
    issue(7'd5, 7'd3, 32'hCAFE0005);
    tick();
    wb_valid_i = '0;
    check("nomatch_d1", out_src1_data_o, 64'hAA);
    check("byp0_d2", out_src2_data_o, 64'hDEAD);

    // Backpressure: three stalled cycles with a second input pending
    issue(7'd5, 7'd12, 32'hCAFE0006);
    tick();
    out_ready_i = 1'b0;
    issue(7'd9, 7'd7, 32'hCAFE0007);
    #1;
    check("stall_ready0", 64'(in_ready_o), skid ? 64'd1 : 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (skid) in_valid_i = 1'b0;
      check("stall_valid", 64'(out_valid_o), 64'd1);
      check("stall_pl", 64'(out_payload_o), 64'hCAFE0006);
      check("stall_d2", out_src2_data_o, 64'h1234);
      check("stall_ready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("rel_pl", 64'(out_payload_o), 64'hCAFE0007);
    check("rel_d1", out_src1_data_o, 64'h99);
    check("rel_d2", out_src2_data_o, 64'h33);
    tick();
    check("rel_empty", 64'(out_valid_o), 64'd0);

    // Flush with a full stage and a pending input
    issue(7'd5, 7'd9, 32'hCAFE0008);
    tick();
    check("fl_fill", 64'(out_payload_o), 64'hCAFE0008);
    out_ready_i = 1'b0;
    if (skid) begin
      issue(7'd9, 7'd9, 32'hCAFE0009);
      tick();
      check("fl_skidfull", 64'(in_ready_o), 64'd0);
    end
    issue(7'd12, 7'd12, 32'hCAFE000A);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_valid", 64'(out_valid_o), 64'd0);
    check("fl_ready", 64'(in_ready_o), 64'd1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    check("fl_noaccept", 64'(out_valid_o), 64'd0);

    // Asynchronous reset between edges
    issue(7'd5, 7'd9, 32'hCAFE000B);
    tick();
    check("ar_fill", 64'(out_valid_o), 64'd1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid_o), 64'd0);
    check("ar_d1", out_src1_data_o, 64'd0);
    check("ar_pl", 64'(out_payload_o), 64'd0);
    reset_n = 1'b1;
    tick();
    check("ar_after", 64'(out_valid_o), 64'd0);
    check("ar_ready", 64'(in_ready_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
